time_digit_counter: RTL

TIME_DIGIT_COUNTER -- requirements
Module: time_digit_counter

---
 rtl/time_digit_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/time_digit_counter.sv
// Single time digit: prescaled up/down counter with run/hold FSM,
// synchronous preset/clear, carry/borrow pulse and registered 7-seg output.
module time_digit_counter #(
  parameter int MODULUS        = 10,
  parameter int PRESCALE       = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       RESET,
  input  logic       tick,
  input  logic       ctrl_en,
  input  logic       start,
  input  logic       stop,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       wrap,
  output logic [6:0] seg,
  output logic       running
);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0]  DIGIT_MAX = 4'(MODULUS - 1);
  localparam logic [15:0] PC_LAST   = 16'(PRESCALE - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [3:0]  digit_next;
  logic        wrap_next;
  logic        step;

  // Segment pattern for a hex value, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~pattern : pattern;
  endfunction

  // Next count, prescaler and wrap; clear overrides load, load overrides step
  always_comb begin
    pc_next    = pc;
    digit_next = digit;
    wrap_next  = 1'b0;
    step       = 1'b0;
    if (state == RUN && tick) begin
      if (pc == PC_LAST) begin
        pc_next = '0;
        step    = 1'b1;
      end else begin
        pc_next = pc + 16'd1;
      end
    end
    if (step) begin
      if (up) begin
        if (digit == DIGIT_MAX) begin
          digit_next = '0;
          wrap_next  = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          digit_next = DIGIT_MAX;
          wrap_next  = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
    if (clear) begin
      digit_next = '0;
      pc_next    = '0;
      wrap_next  = 1'b0;
    end else if (load) begin
      digit_next = (load_value > DIGIT_MAX) ? DIGIT_MAX : load_value;
      pc_next    = '0;
      wrap_next  = 1'b0;
    end
  end

  // Run/hold request decoding; stop dominates start
  always_comb begin
    state_next = state;
    if (ctrl_en) begin
      if (stop) begin
        state_next = HOLD;
      end else if (start) begin
        state_next = RUN;
      end
    end
  end

  // State, count and registered outputs; seg follows digit_next so both land together
  always_ff @(posedge clock) begin
    if (!RESET) begin
      state   <= HOLD;
      running <= 1'b0;
      pc      <= '0;
      digit   <= '0;
      wrap    <= 1'b0;
      seg     <= seg_encode(4'd0);
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      pc      <= pc_next;
      digit   <= digit_next;
      wrap    <= wrap_next;
      seg     <= seg_encode(digit_next);
    end
  end

endmodule
